bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble).
// One iteration per clock: W_BIN shift cycles plus a single DONE cycle.
// Digits that fall off the top of the working register set the overflow
// flag; the low N_DIGITS decimal digits stay correct either way.

// Per-digit double-dabble correction: add 3 to any digit >= 5 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);
  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bin_to_bcd_seq #(
  parameter int W_BIN    = 27,
  parameter int N_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W_BIN-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  ovf
);
  localparam int CNT_W = $clog2(W_BIN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                     state_q, state_d;
  logic [W_BIN-1:0]           bin_q, bin_d;
  logic [N_DIGITS-1:0][3:0]   work_q, work_d;
  logic                       acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [N_DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic                       ovf_q, ovf_d;

  // Corrected digits and the result of shifting {corrected, bin MSB} left.
  logic [N_DIGITS-1:0][3:0]   work_adj;
  logic [N_DIGITS-1:0][3:0]   work_shl;
  logic                       shift_out;

  // One correction unit per BCD digit.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .dig_i (work_q[g]),
      .dig_o (work_adj[g])
    );
  end

  // Bit leaving the top digit feeds the overflow accumulator.
  assign {shift_out, work_shl} = {work_adj, bin_q[W_BIN-1]};

  // Next-state and datapath control; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = CNT_W'(W_BIN);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_shl;
        bin_d  = bin_q << 1;
        acc_d  = acc_q | shift_out;
        cnt_d  = cnt_q - CNT_W'(1);
        // Last iteration: publish the result on the same edge that enters
        // DONE so bcd/ovf are already valid while done is high.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = work_shl;
          ovf_d   = acc_q | shift_out;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; it is not queued.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq at default parameters (27-bit in, 8 digits).
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [26:0] bin;
  logic        busy, done, ovf;
  logic [31:0] bcd;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and follow it to done (bounded). Optionally alter
  // bin in cycle chg_cyc. Reports latency (-1 on timeout), result, number of
  // cycles with busy low, and number of cycles where bcd/ovf moved early.
  task automatic convert(input logic [26:0] v, input int chg_cyc,
                         input logic [26:0] chg_val, output int lat,
                         output logic [31:0] r, output logic o,
                         output int busy_bad, output int held_bad);
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    int          c;
    prev_bcd = bcd;
    prev_ovf = ovf;
    lat = -1; r = '0; o = 1'b0; busy_bad = 0; held_bad = 0;
    bin = v; start = 1'b1;
    tick();                       // accepting edge (cycle 0)
    start = 1'b0;
    c = 1;
    while (c <= 40) begin
      if (c == chg_cyc) bin = chg_val;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = c; r = bcd; o = ovf;
        break;
      end
      if (bcd !== prev_bcd || ovf !== prev_ovf) held_bad++;
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bin = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL reset_bcd got %h want 00000000", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_zero();
    int lat, bb, hb; logic [31:0] r; logic o;
    convert(27'd0, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (lat !== 28) begin errors++; $display("FAIL zero_lat got %0d want 28", lat); end
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL zero_bcd got %h want 00000000", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_ovf got %b want 0", o); end
    tick();
  endtask

  task automatic test_basic();
    int lat, bb, hb; logic [31:0] r; logic o;
    convert(27'd12345678, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (lat !== 28) begin errors++; $display("FAIL basic_lat got %0d want 28", lat); end
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL basic_bcd got %h want 12345678", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", o); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy low_cycles %0d want 0", bb); end
    tick();                       // cycle 29: back in IDLE
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    tick(); tick();
    checks++; if (bcd !== 32'h12345678) begin errors++; $display("FAIL basic_hold got %h want 12345678", bcd); end
  endtask

  task automatic test_overflow();
    int lat, bb, hb; logic [31:0] r; logic o;
    convert(27'd99999999, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (hb !== 0) begin errors++; $display("FAIL max_hold_prev moved %0d want 0", hb); end
    checks++; if (r !== 32'h99999999) begin errors++; $display("FAIL max_bcd got %h want 99999999", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL max_ovf got %b want 0", o); end
    tick();
    convert(27'd100000000, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL ovf1_bcd got %h want 00000000", r); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got %b want 1", o); end
    tick();
    convert(27'd134217727, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (r !== 32'h34217727) begin errors++; $display("FAIL ovf2_bcd got %h want 34217727", r); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf2_ovf got %b want 1", o); end
    checks++; if (lat !== 28) begin errors++; $display("FAIL ovf2_lat got %0d want 28", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int first, second, extra;
    first = -1; second = -1; extra = 0;
    bin = 27'd42; start = 1'b1;
    tick();                       // accepting edge = cycle 0
    for (int c = 1; c <= 60; c++) begin
      if (done === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
        else extra++;
        checks++; if (bcd !== 32'h00000042) begin errors++; $display("FAIL b2b_bcd cyc %0d got %h want 00000042", c, bcd); end
      end
      if (c == 57) start = 1'b0;
      tick();
    end
    checks++; if (first !== 28) begin errors++; $display("FAIL b2b_first got %0d want 28", first); end
    checks++; if (second !== 57) begin errors++; $display("FAIL b2b_second got %0d want 57", second); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra got %0d want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bb, hb; logic [31:0] r; logic o; int seen;
    bin = 27'd87654321; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();   // now in cycle 10
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL rmid_bcd got %h want 00000000", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", ovf); end
    tick(); tick();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_aborted active_cycles %0d want 0", seen); end
    convert(27'd87654321, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (lat !== 28) begin errors++; $display("FAIL rmid_lat got %0d want 28", lat); end
    checks++; if (r !== 32'h87654321) begin errors++; $display("FAIL rmid_bcd_restart got %h want 87654321", r); end
    tick();
  endtask

  task automatic test_reset_release_start();
    int lat, bb, hb; logic [31:0] r; logic o;
    reset = 1'b1;
    tick();
    reset = 1'b0;                 // start offered on the first edge after release
    convert(27'd7, 0, 27'd0, lat, r, o, bb, hb);
    checks++; if (lat !== 28) begin errors++; $display("FAIL rel_lat got %0d want 28", lat); end
    checks++; if (r !== 32'h00000007) begin errors++; $display("FAIL rel_bcd got %h want 00000007", r); end
    tick();
  endtask

  task automatic test_bin_change();
    int lat, bb, hb; logic [31:0] r; logic o;
    convert(27'd1000, 3, 27'd5, lat, r, o, bb, hb);
    checks++; if (r !== 32'h00001000) begin errors++; $display("FAIL binchg_bcd got %h want 00001000", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL binchg_ovf got %b want 0", o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_reset_release_start();
    test_bin_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
